// File: rtl/sprite_rom_arbiter.sv
// sprite_rom_arbiter: shares one synchronous sprite/colour ROM between N_REQ readers.
// Requester 0 (VGA pixel path) has strict priority; game-logic readers 1..N_REQ-1
// share the ROM round-robin and may preempt requester 0 once one of them has waited
// MAX_STARVE cycles. Read data returns in issue order, tagged one-hot to its issuer.
module sprite_rom_arbiter #(
  parameter int N_REQ      = 4,
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int ROM_LAT    = 1,
  parameter int MAX_STARVE = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*ADDR_W-1:0] addr,
  output logic [N_REQ-1:0]        gnt,
  output logic                    rom_en,
  output logic [ADDR_W-1:0]       rom_addr,
  input  logic [DATA_W-1:0]       rom_data,
  output logic [N_REQ-1:0]        rd_valid,
  output logic [DATA_W-1:0]       rd_data,
  output logic                    starve_hit
);

  localparam int CNT_W = $clog2(MAX_STARVE + 1);
  localparam int PTR_W = $clog2(N_REQ);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_STARVE);
  localparam logic [PTR_W-1:0] PTR_FIRST = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(N_REQ - 1);

  logic [PTR_W-1:0]  rr_ptr;
  logic [CNT_W-1:0]  wait_cnt [1:N_REQ-1];
  logic [N_REQ-1:0]  starving;
  logic [PTR_W-1:0]  gnt_idx;
  logic [ADDR_W-1:0] gnt_addr;
  // tag_p[0] is aligned with rom_en; tag_p[ROM_LAT] is aligned with valid rom_data.
  logic [N_REQ-1:0]  tag_p [0:ROM_LAT];

  // One-hot of the first set candidate among 1..N_REQ-1, starting at ptr and wrapping
  // N_REQ-1 -> 1. Bit 0 is never considered.
  function automatic logic [N_REQ-1:0] pick_rr(input logic [N_REQ-1:0] cand,
                                              input logic [PTR_W-1:0] ptr);
    logic [N_REQ-1:0] sel;
    logic [PTR_W-1:0] pos;
    int               idx;
    sel = '0;
    // Walk the ring backwards so the candidate nearest to ptr is written last and wins.
    for (int k = N_REQ - 2; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= N_REQ) idx = idx - (N_REQ - 1);
      pos = PTR_W'(idx);
      if (cand[pos]) begin
        sel      = '0;
        sel[pos] = 1'b1;
      end
    end
    return sel;
  endfunction

  // Low requesters that are still asking and have hit the starvation limit.
  always_comb begin
    starving = '0;
    for (int i = 1; i < N_REQ; i++)
      starving[i] = req[i] && (wait_cnt[i] == CNT_MAX);
  end

  // Grant selection: starvation override, then requester 0, then round-robin.
  always_comb begin
    gnt        = '0;
    starve_hit = 1'b0;
    if (!rst) begin
      if (|starving) begin
        gnt        = pick_rr(starving, rr_ptr);
        starve_hit = 1'b1;
      end else if (req[0]) begin
        gnt[0] = 1'b1;
      end else begin
        gnt = pick_rr(req, rr_ptr);
      end
    end
  end

  // Encode the winner and select its address.
  always_comb begin
    gnt_idx  = '0;
    gnt_addr = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        gnt_idx  = PTR_W'(i);
        gnt_addr = addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  // ---- p0: issue register (ROM command) and round-robin pointer ----
  // Register the ROM command for the winner; advance the ring past a low winner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_en   <= 1'b0;
      rom_addr <= '0;
      rr_ptr   <= PTR_FIRST;
    end else begin
      rom_en <= |gnt;
      if (|gnt) rom_addr <= gnt_addr;
      if (|gnt[N_REQ-1:1]) rr_ptr <= (gnt_idx == PTR_LAST) ? PTR_FIRST : gnt_idx + PTR_W'(1);
    end
  end

  // Wait counters: count cycles a low requester asks without winning, saturating.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i < N_REQ; i++) wait_cnt[i] <= '0;
    end else begin
      for (int i = 1; i < N_REQ; i++) begin
        if (req[i] && !gnt[i]) begin
          if (wait_cnt[i] != CNT_MAX) wait_cnt[i] <= wait_cnt[i] + CNT_W'(1);
        end else begin
          wait_cnt[i] <= '0;
        end
      end
    end
  end

  // ---- p1..pROM_LAT: return tag pipeline tracking the ROM's internal latency ----
  // Shift the owner tag alongside the ROM read so data comes back labelled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k <= ROM_LAT; k++) tag_p[k] <= '0;
    end else begin
      tag_p[0] <= gnt;
      for (int k = 1; k <= ROM_LAT; k++) tag_p[k] <= tag_p[k-1];
    end
  end

  assign rd_valid = tag_p[ROM_LAT];
  assign rd_data  = rom_data;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Bench for sprite_rom_arbiter: two instances (ROM latency 1 and 3) share the same
// request stimulus, each fed by its own behavioural ROM. A transaction-level model
// predicts grants, ROM commands and tagged returns cycle by cycle.
module tb_sprite_rom_arbiter;
  localparam int N    = 4;
  localparam int AW   = 16;
  localparam int DW   = 16;
  localparam int MAXS = 15;
  localparam int HMAX = 4096;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req;
  logic [N*AW-1:0] addr;
  logic [N-1:0]  gnt1, gnt3, rv1, rv3;
  logic          en1, en3, sh1, sh3;
  logic [AW-1:0] ra1, ra3;
  logic [DW-1:0] rdat1, rdat3, rd1, rd3;
  logic [DW-1:0] rom3_q [3];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Model state
  int            hist_req  [HMAX];
  logic [AW-1:0] hist_addr [HMAX];
  int            m_rr;
  int            m_wait [N];
  int            m_pend [N];
  logic [AW-1:0] m_rom_addr;
  int            m_last_g;

  // Observations captured mid-cycle by tick()
  logic [N-1:0]  obs_gnt1, obs_rv1, obs_rv3;
  logic          obs_sh1, obs_en1;
  logic [AW-1:0] obs_ra1;
  logic [DW-1:0] obs_rd1;

  always #5 clk = ~clk;

  sprite_rom_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(1), .MAX_STARVE(MAXS)) u_lat1 (
    .clk(clk), .rst(rst), .req(req), .addr(addr), .gnt(gnt1), .rom_en(en1), .rom_addr(ra1),
    .rom_data(rdat1), .rd_valid(rv1), .rd_data(rd1), .starve_hit(sh1));

  sprite_rom_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(3), .MAX_STARVE(MAXS)) u_lat3 (
    .clk(clk), .rst(rst), .req(req), .addr(addr), .gnt(gnt3), .rom_en(en3), .rom_addr(ra3),
    .rom_data(rdat3), .rd_valid(rv3), .rd_data(rd3), .starve_hit(sh3));

  function automatic logic [DW-1:0] rom_f(input logic [AW-1:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  // Synchronous ROMs with latency 1 and 3
  always @(posedge clk) if (en1) rdat1 <= rom_f(ra1);
  always @(posedge clk) begin
    rom3_q[0] <= en3 ? rom_f(ra3) : 'x;
    rom3_q[1] <= rom3_q[0];
    rom3_q[2] <= rom3_q[1];
  end
  assign rdat3 = rom3_q[2];

  function automatic logic [N-1:0] oh(input int g);
    logic [N-1:0] v;
    v = '0;
    if (g >= 0) v[g] = 1'b1;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // k-th low requester in current round-robin order
  function automatic int lo_at(input int k);
    return ((m_rr - 1 + k) % (N - 1)) + 1;
  endfunction

  function automatic int model_grant(output bit sh);
    int g;
    g  = -1;
    sh = 1'b0;
    if (rst !== 1'b0) return -1;
    for (int k = 0; k < N - 1; k++)
      if (g < 0 && req[lo_at(k)] && m_wait[lo_at(k)] >= MAXS) begin
        g  = lo_at(k);
        sh = 1'b1;
      end
    if (g < 0 && req[0]) g = 0;
    for (int k = 0; k < N - 1; k++)
      if (g < 0 && req[lo_at(k)]) g = lo_at(k);
    return g;
  endfunction

  task automatic model_reset();
    m_rr       = 1;
    m_rom_addr = '0;
    m_last_g   = -1;
    for (int i = 0; i < N; i++) begin
      m_wait[i] = 0;
      m_pend[i] = 0;
    end
    for (int j = 0; j < HMAX; j++) hist_req[j] = -1;
  endtask

  // One clock cycle: predict, check mid-cycle, then advance the model at the edge.
  task automatic tick();
    int           g, t;
    bit           sh;
    logic [N-1:0] ev;
    if (rst) model_reset();
    g = model_grant(sh);
    @(negedge clk);
    obs_gnt1 = gnt1; obs_sh1 = sh1; obs_en1 = en1; obs_ra1 = ra1;
    obs_rv1 = rv1; obs_rv3 = rv3; obs_rd1 = rd1;
    chk("gnt_l1", 32'(gnt1), 32'(oh(g)));
    chk("gnt_l3", 32'(gnt3), 32'(oh(g)));
    chk("starve_hit_l1", 32'(sh1), 32'(sh));
    chk("starve_hit_l3", 32'(sh3), 32'(sh));
    chk("rom_en_l1", 32'(en1), 32'(cyc > 0 && hist_req[cyc-1] >= 0));
    chk("rom_en_l3", 32'(en3), 32'(cyc > 0 && hist_req[cyc-1] >= 0));
    chk("rom_addr_l1", 32'(ra1), 32'(m_rom_addr));
    chk("rom_addr_l3", 32'(ra3), 32'(m_rom_addr));
    t  = cyc - 2;
    ev = (t >= 0 && hist_req[t] >= 0) ? oh(hist_req[t]) : '0;
    chk("rd_valid_l1", 32'(rv1), 32'(ev));
    if (ev != '0) chk("rd_data_l1", 32'(rd1), 32'(rom_f(hist_addr[t])));
    t  = cyc - 4;
    ev = (t >= 0 && hist_req[t] >= 0) ? oh(hist_req[t]) : '0;
    chk("rd_valid_l3", 32'(rv3), 32'(ev));
    if (ev != '0) chk("rd_data_l3", 32'(rd3), 32'(rom_f(hist_addr[t])));
    @(posedge clk);
    if (!rst) begin
      hist_req[cyc] = g;
      if (g >= 0) begin
        hist_addr[cyc] = addr[g*AW +: AW];
        m_rom_addr     = hist_addr[cyc];
        if (g != 0) m_rr = (g == N - 1) ? 1 : g + 1;
      end
      for (int i = 1; i < N; i++) begin
        if (req[i] && g != i) begin
          m_wait[i] = (m_wait[i] < MAXS) ? m_wait[i] + 1 : MAXS;
          m_pend[i]++;
        end else begin
          if (g == i) chk("starve_bound", 32'(m_pend[i] <= MAXS + N - 1), 32'(1));
          m_wait[i] = 0;
          m_pend[i] = 0;
        end
      end
    end
    m_last_g = g;
    cyc++;
    #1;
  endtask

  task automatic drive_random();
    for (int i = 0; i < N; i++) begin
      if (req[i] && m_last_g != i) begin
        if ($urandom_range(0, 99) < 3) req[i] = 1'b0;
      end else begin
        req[i] = ($urandom_range(0, 99) < ((i == 0) ? 70 : 40));
        addr[i*AW +: AW] = AW'($urandom);
      end
    end
  endtask

  int           exp_seq [6] = '{1, 2, 3, 1, 2, 3};
  logic [N-1:0] rv3_seq [8];
  logic [N-1:0] rv3_exp [8] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0100, 4'b0001, 4'b0000};

  initial begin
    // T1: reset with all requests high
    rst  = 1'b1;
    req  = 4'b1111;
    addr = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    tick();
    chk("T1 gnt in reset", 32'(obs_gnt1), 32'(0));
    chk("T1 rom_en in reset", 32'(obs_en1), 32'(0));
    chk("T1 rd_valid in reset", 32'(obs_rv1), 32'(0));
    tick();
    rst = 1'b0;
    tick();
    chk("T1 gnt after release", 32'(obs_gnt1), 32'(4'b0001));
    req = '0;
    repeat (5) tick();

    // T2: single read from requester 1
    req = 4'b0010;
    addr[1*AW +: AW] = 16'h1234;
    tick();
    chk("T2 gnt", 32'(obs_gnt1), 32'(4'b0010));
    req = '0;
    tick();
    chk("T2 rom_en", 32'(obs_en1), 32'(1));
    chk("T2 rom_addr", 32'(obs_ra1), 32'(16'h1234));
    tick();
    chk("T2 rd_valid", 32'(obs_rv1), 32'(4'b0010));
    chk("T2 rd_data", 32'(obs_rd1), 32'(rom_f(16'h1234)));
    repeat (4) tick();

    // T3: round-robin among low requesters from a fresh pointer
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 4'b1110;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("T3 rr order", 32'(obs_gnt1), 32'(oh(exp_seq[k])));
    end
    req = '0;
    repeat (4) tick();

    // T4: requester 0 hogs, requester 1 preempts after MAX_STARVE cycles
    req = 4'b0011;
    for (int k = 1; k <= 17; k++) begin
      tick();
      chk("T4 gnt", 32'(obs_gnt1), 32'((k == 16) ? 4'b0010 : 4'b0001));
      chk("T4 starve_hit", 32'(obs_sh1), 32'(k == 16));
    end
    req = '0;
    repeat (4) tick();

    // T5: back-to-back transfers 0,2,0 through the latency-3 instance
    req = 4'b0101;
    addr[0*AW +: AW] = 16'hA000;
    addr[2*AW +: AW] = 16'hB222;
    tick();
    rv3_seq[0] = obs_rv3;
    req = 4'b0100;
    addr[0*AW +: AW] = 16'hA0A0;
    tick();
    rv3_seq[1] = obs_rv3;
    req = 4'b0001;
    tick();
    rv3_seq[2] = obs_rv3;
    req = '0;
    for (int k = 3; k < 8; k++) begin
      tick();
      rv3_seq[k] = obs_rv3;
    end
    for (int k = 0; k < 8; k++) chk("T5 rd_valid_l3 seq", 32'(rv3_seq[k]), 32'(rv3_exp[k]));

    // T6: reset one cycle after a transfer drops its return
    req = 4'b0010;
    addr[1*AW +: AW] = 16'hC0DE;
    tick();
    req = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("T6 rd_valid_l3", 32'(obs_rv3), 32'(0));
      chk("T6 rd_valid_l1", 32'(obs_rv1), 32'(0));
    end

    // Randomized traffic with occasional resets
    for (int n = 0; n < 800; n++) begin
      drive_random();
      rst = ($urandom_range(0, 249) == 0);
      tick();
    end
    rst = 1'b0;
    req = '0;
    repeat (6) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
